// File: rtl/adc_gen_pkg.sv
// Shared definitions for the NCO test-tone source: controller states,
// peak-amplitude helper and the cosine table builder used by the ROM.
`timescale 1ns/1ps
package adc_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    // Full-scale peak of a signed quantiser of the given width.
    function automatic int peak_of(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    // Entry k of a full cosine period spread over 2**lut_aw entries,
    // rounded to nearest and scaled to the quantiser peak.
    function automatic int cos_rom(input int lut_aw, input int bits, input int k);
        real ang;
        ang = 2.0 * 3.141592653589793 * real'(k) / real'(1 << lut_aw);
        return int'($cos(ang) * real'(peak_of(bits)));
    endfunction

endpackage

// File: rtl/nco_cos_rom.sv
// Dual-read synchronous cosine ROM. Both ports read the same table; the
// caller offsets one address by a quarter period to obtain sine.
`timescale 1ns/1ps
module nco_cos_rom
    import adc_gen_pkg::*;
#(
    parameter int BITS   = 12,
    parameter int LUT_AW = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [LUT_AW-1:0]        addr_i,
    input  logic [LUT_AW-1:0]        addr_q,
    output logic signed [BITS-1:0]   data_i,
    output logic signed [BITS-1:0]   data_q
);

    localparam int DEPTH = 1 << LUT_AW;

    logic signed [BITS-1:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = BITS'(cos_rom(LUT_AW, BITS, k));
    end

    // Registered read; only updates when the pipe advances so held beats stay stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_i <= '0;
            data_q <= '0;
        end else if (en) begin
            data_i <= rom[addr_i];
            data_q <= rom[addr_q];
        end
    end

endmodule

// File: rtl/adc_nco_gen.sv
// Phase-accumulator NCO test source on an AXI-Stream master. Produces a real
// or complex quantised tone, in bursts or continuously, honouring tready.
// Pipe: phase register (ROM address) -> ROM read register (output beat).
`timescale 1ns/1ps
module adc_nco_gen
    import adc_gen_pkg::*;
#(
    parameter     DTYPE   = "CX",
    parameter int BITS    = 12,
    parameter int TWID    = 16,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic                                          stop,
    input  logic [PHASE_W-1:0]                            cfg_phase_inc,
    input  logic [3:0]                                    cfg_amp_shift,
    input  logic [31:0]                                   cfg_num_samps,
    output logic                                          busy,
    output logic [((DTYPE == "CX") ? 2*TWID : TWID)-1:0]  m_axis_tdata,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready
);

    localparam logic [LUT_AW-1:0] QUARTER = LUT_AW'(1) << (LUT_AW - 2);

    gen_state_t state, state_nxt;

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] inc_q;
    logic [31:0]        count;
    logic [31:0]        num_q;
    logic [3:0]         shift_q;

    logic               adv;
    logic               issue;
    logic               last;

    logic [LUT_AW-1:0]      addr_i;
    logic [LUT_AW-1:0]      addr_q;
    logic signed [BITS-1:0] rom_i;
    logic signed [BITS-1:0] rom_q;
    logic signed [TWID-1:0] i_ext;
    logic signed [TWID-1:0] q_ext;
    logic signed [TWID-1:0] i_shf;
    logic signed [TWID-1:0] q_shf;

    assign adv  = !m_axis_tvalid || m_axis_tready;
    assign last = (num_q != '0) && ((count + 32'd1) == num_q);
    assign busy = (state != IDLE);

    // Next state and beat issue: stop blocks issue, the Nth issued beat ends the burst.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_nxt = DONE;
                end else if (adv) begin
                    issue = 1'b1;
                    if (last) state_nxt = DONE;
                end
            end
            DONE: begin
                // The single output register empties on this advance.
                if (adv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched configuration, phase accumulator and issued-beat count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            phase   <= '0;
            inc_q   <= '0;
            count   <= '0;
            num_q   <= '0;
            shift_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                inc_q   <= cfg_phase_inc;
                num_q   <= cfg_num_samps;
                shift_q <= cfg_amp_shift;
                phase   <= '0;
                count   <= '0;
            end else if (issue) begin
                phase <= phase + inc_q;
                count <= count + 32'd1;
            end
        end
    end

    // Output-beat valid: set when a beat is issued, cleared when consumed with nothing behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axis_tvalid <= 1'b0;
        end else if (issue) begin
            m_axis_tvalid <= 1'b1;
        end else if (adv) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    assign addr_i = phase[PHASE_W-1 -: LUT_AW];
    assign addr_q = addr_i - QUARTER;

    nco_cos_rom #(
        .BITS   (BITS),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .en     (issue),
        .addr_i (addr_i),
        .addr_q (addr_q),
        .data_i (rom_i),
        .data_q (rom_q)
    );

    // The shift is held constant for the whole burst, so applying it after the
    // ROM register keeps stalled beats stable.
    assign i_ext = TWID'(rom_i);
    assign q_ext = TWID'(rom_q);
    assign i_shf = i_ext >>> shift_q;
    assign q_shf = q_ext >>> shift_q;

    if (DTYPE == "CX") begin : g_cx
        assign m_axis_tdata = {q_shf, i_shf};
    end else begin : g_re
        logic unused_q;
        assign unused_q     = ^q_shf;
        assign m_axis_tdata = i_shf;
    end

endmodule
